// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one fixed-latency divider between two requesters.
// Round-robin arbitration, locally answered divide-by-zero, and per-requester
// response hold until the owner takes the result.
module div_share_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DIV_LATENCY = 40
) (
    input  logic             clk,
    input  logic             rstn,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_dz,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_dz,

    output logic             div_enable,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_result,

    output logic             busy
);

    localparam int unsigned CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_grant;
    logic               r_tag;
    logic [WIDTH-1:0]   r_div_dividend;
    logic [WIDTH-1:0]   r_div_divisor;
    logic [WIDTH-1:0]   r_rsp0_result;
    logic [WIDTH-1:0]   r_rsp1_result;
    logic               r_rsp0_dz;
    logic               r_rsp1_dz;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_accept;
    logic               w_acc_tag;
    logic [WIDTH-1:0]   w_acc_dividend;
    logic [WIDTH-1:0]   w_acc_divisor;
    logic               w_acc_zero;
    logic               w_cnt_done;
    logic               w_rsp_taken;

    // A lone requester always wins; on contention the one not served last wins.
    assign w_grant0       = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1       = req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept       = (r_state == S_IDLE) && (w_grant0 || w_grant1);
    assign w_acc_tag      = w_grant1;
    assign w_acc_dividend = w_acc_tag ? req1_dividend : req0_dividend;
    assign w_acc_divisor  = w_acc_tag ? req1_divisor  : req0_divisor;
    assign w_acc_zero     = (w_acc_divisor == '0);
    assign w_cnt_done     = (r_cnt == CNT_LAST);
    assign w_rsp_taken    = r_tag ? rsp1_ready : rsp0_ready;

    assign div_dividend = r_div_dividend;
    assign div_divisor  = r_div_divisor;
    assign rsp0_result  = r_rsp0_result;
    assign rsp1_result  = r_rsp1_result;
    assign rsp0_dz      = r_rsp0_dz;
    assign rsp1_dz      = r_rsp1_dz;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the state-derived handshake and divider outputs.
    always_comb begin
        w_next_state = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        div_enable   = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy       = 1'b0;
                req0_ready = w_grant0;
                req1_ready = w_grant1;
                if (w_accept) begin
                    w_next_state = w_acc_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_BUSY;
            end
            S_BUSY: begin
                div_enable = 1'b1;
                if (w_cnt_done) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                rsp0_valid = !r_tag;
                rsp1_valid = r_tag;
                if (w_rsp_taken) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand latch, latency counter, arbitration history and result capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt          <= '0;
            r_last_grant   <= 1'b1;
            r_tag          <= 1'b0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_rsp0_result  <= '0;
            r_rsp1_result  <= '0;
            r_rsp0_dz      <= 1'b0;
            r_rsp1_dz      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tag        <= w_acc_tag;
                        r_last_grant <= w_acc_tag;
                        if (w_acc_zero) begin
                            // Answered locally; divider operands keep their old values.
                            if (w_acc_tag) begin
                                r_rsp1_result <= '1;
                                r_rsp1_dz     <= 1'b1;
                            end else begin
                                r_rsp0_result <= '1;
                                r_rsp0_dz     <= 1'b1;
                            end
                        end else begin
                            r_div_dividend <= w_acc_dividend;
                            r_div_divisor  <= w_acc_divisor;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_cnt_done) begin
                        r_cnt <= '0;
                        if (r_tag) begin
                            r_rsp1_result <= div_result;
                            r_rsp1_dz     <= 1'b0;
                        end else begin
                            r_rsp0_result <= div_result;
                            r_rsp0_dz     <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: a behavioural divider with fixed latency sits on
// the divider port; requesters are driven per scenario and checked against
// quotient/arbitration rules computed here.
module tb_div_share_ctrl;

    localparam int unsigned W = 32;
    localparam int unsigned L = 40;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_dz;
    logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_dz;
    logic [W-1:0] req0_dividend, req0_divisor, rsp0_result;
    logic [W-1:0] req1_dividend, req1_divisor, rsp1_result;
    logic         div_enable, busy;
    logic [W-1:0] div_dividend, div_divisor, div_result;

    int total = 0;
    int bad   = 0;
    int tb_last;
    int en_cycles = 0;

    always #5 clk = ~clk;

    div_share_ctrl #(.WIDTH(W), .DIV_LATENCY(L)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_dz(rsp0_dz),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_dz(rsp1_dz),
        .div_enable(div_enable), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_result(div_result), .busy(busy)
    );

    // Divider stand-in: quotient is only correct once enable has been high
    // for L-1 completed cycles; earlier it shows a wrong value.
    always @(posedge clk) en_cycles <= div_enable ? en_cycles + 1 : 0;
    always_comb begin
        div_result = '1;
        if (div_divisor != '0)
            div_result = (en_cycles >= L - 1) ? div_dividend / div_divisor
                                              : ~(div_dividend / div_divisor);
    end

    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {1'b1, {W{1'b1}}};
        return {1'b0, a / b};
    endfunction

    function automatic logic [4*W+7:0] outs();
        return {busy, div_enable, div_dividend, div_divisor, rsp0_valid, rsp0_result,
                rsp0_dz, rsp1_valid, rsp1_result, rsp1_dz, req0_ready, req1_ready};
    endfunction

    function automatic logic get_rsp_valid(input int p);
        return (p == 0) ? rsp0_valid : rsp1_valid;
    endfunction
    function automatic logic [W-1:0] get_result(input int p);
        return (p == 0) ? rsp0_result : rsp1_result;
    endfunction
    function automatic logic get_dz(input int p);
        return (p == 0) ? rsp0_dz : rsp1_dz;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        if (p == 0) begin
            req0_valid = v; req0_dividend = a; req0_divisor = b;
        end else begin
            req1_valid = v; req1_dividend = a; req1_divisor = b;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) rsp0_ready = v;
        else        rsp1_ready = v;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tb_last = 1;
    endtask

    // Waits (bounded) for an accepting edge; returns in the cycle after accept.
    task automatic wait_accept(output int port, output int waited, output bit both, output bit to);
        port = -1; waited = 0; both = 0; to = 1;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (req0_ready && req1_ready) both = 1;
            if (req0_ready || req1_ready) begin
                port = req0_ready ? 0 : 1;
                to = 0;
                tick();
                break;
            end
            waited++;
            tick();
        end
    endtask

    // Follows an accepted op to its response, applies bp cycles of
    // backpressure, then takes the result; reports what it observed.
    task automatic finish_op(input int port, input int bp, output logic [W-1:0] res,
                             output logic dz, output int lat, output int en,
                             output bit other_rsp, output bit rdy_seen,
                             output bit unstable, output bit drop_bad, output bit to);
        res = '0; dz = 1'b0; lat = 1; en = 0;
        other_rsp = 0; rdy_seen = 0; unstable = 0; drop_bad = 0; to = 1;
        set_rsp_ready(port, 1'b0);
        for (int i = 0; i < 400; i++) begin
            #1;
            if (get_rsp_valid(1 - port)) other_rsp = 1;
            if (req0_ready || req1_ready) rdy_seen = 1;
            if (get_rsp_valid(port)) begin
                to = 0;
                break;
            end
            if (div_enable) en++;
            lat++;
            tick();
        end
        if (to) return;
        res = get_result(port);
        dz  = get_dz(port);
        for (int b = 0; b < bp; b++) begin
            tick();
            #1;
            if (!get_rsp_valid(port) || get_result(port) !== res || get_dz(port) !== dz) unstable = 1;
            if (get_rsp_valid(1 - port)) other_rsp = 1;
            if (req0_ready || req1_ready) rdy_seen = 1;
        end
        set_rsp_ready(port, 1'b1);
        tick();
        set_rsp_ready(port, 1'b0);
        #1;
        if (get_rsp_valid(port) || busy) drop_bad = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        rstn = 1'b0;
        tick();
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h want=0", outs());
        end
        rstn = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || div_enable !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%0b en=%0b want 0 0", busy, div_enable);
        end
    endtask

    task automatic test_single();
        int port, waited, lat, en;
        bit both, to, orsp, rdy, unst, drop;
        logic [W-1:0] res;
        logic dz;
        logic [W:0] exp;
        exp = ref_op(100, 7);
        set_req(0, 1'b1, 100, 7);
        wait_accept(port, waited, both, to);
        set_req(0, 1'b0, '0, '0);
        total++;
        if (to || port !== 0) begin
            bad++;
            $display("FAIL single_accept got port=%0d timeout=%0b want port=0", port, to);
        end
        tb_last = 0;
        finish_op(0, 0, res, dz, lat, en, orsp, rdy, unst, drop, to);
        total++;
        if (to || lat !== 2 + L) begin
            bad++;
            $display("FAIL single_latency got=%0d timeout=%0b want=%0d", lat, to, 2 + L);
        end
        total++;
        if (en !== L) begin
            bad++;
            $display("FAIL single_enable_cycles got=%0d want=%0d", en, L);
        end
        total++;
        if ({dz, res} !== exp) begin
            bad++;
            $display("FAIL single_result got dz=%0b q=%0d want dz=%0b q=%0d", dz, res, exp[W], exp[W-1:0]);
        end
        total++;
        if (orsp || drop || div_dividend !== 100 || div_divisor !== 7) begin
            bad++;
            $display("FAIL single_side other=%0b drop=%0b dd=%0d ds=%0d want 0 0 100 7",
                     orsp, drop, div_dividend, div_divisor);
        end
    endtask

    task automatic test_contention();
        int port, waited, lat, en, expp;
        bit both, to, orsp, rdy, unst, drop;
        logic [W-1:0] res, a[2], b[2];
        logic dz;
        logic [W:0] exp;
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            a[p] = $urandom;
            b[p] = $urandom_range(1, 5000);
            set_req(p, 1'b1, a[p], b[p]);
        end
        for (int r = 0; r < 3; r++) begin
            expp = (tb_last == 0) ? 1 : 0;
            exp  = ref_op(a[expp], b[expp]);
            wait_accept(port, waited, both, to);
            total++;
            if (to || both || port !== expp) begin
                bad++;
                $display("FAIL contention_grant round=%0d got=%0d both=%0b want=%0d", r, port, both, expp);
            end
            tb_last = expp;
            // Winner immediately re-requests so both stay valid next round.
            a[expp] = $urandom;
            b[expp] = $urandom_range(1, 5000);
            set_req(expp, 1'b1, a[expp], b[expp]);
            finish_op(expp, 0, res, dz, lat, en, orsp, rdy, unst, drop, to);
            total++;
            if (to || {dz, res} !== exp || rdy || orsp) begin
                bad++;
                $display("FAIL contention_result round=%0d got=%0h ready_seen=%0b want=%0h", r, {dz, res}, rdy, exp);
            end
        end
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
    endtask

    task automatic test_div_zero();
        int port, waited, lat, en;
        bit both, to, orsp, rdy, unst, drop;
        logic [W-1:0] res, old_dd, old_ds;
        logic dz;
        old_dd = div_dividend;
        old_ds = div_divisor;
        set_req(1, 1'b1, 5, 0);
        wait_accept(port, waited, both, to);
        set_req(1, 1'b0, '0, '0);
        tb_last = 1;
        finish_op(1, 0, res, dz, lat, en, orsp, rdy, unst, drop, to);
        total++;
        if (to || port !== 1 || lat !== 1) begin
            bad++;
            $display("FAIL dz_latency got port=%0d lat=%0d want port=1 lat=1", port, lat);
        end
        total++;
        if (res !== {W{1'b1}} || dz !== 1'b1) begin
            bad++;
            $display("FAIL dz_result got q=%0h dz=%0b want q=ffffffff dz=1", res, dz);
        end
        total++;
        if (en !== 0 || div_dividend !== old_dd || div_divisor !== old_ds || orsp) begin
            bad++;
            $display("FAIL dz_divider en=%0d dd=%0h ds=%0h other=%0b want en=0 dd=%0h ds=%0h other=0",
                     en, div_dividend, div_divisor, orsp, old_dd, old_ds);
        end
    endtask

    task automatic test_backpressure();
        int port, waited, lat, en;
        bit both, to, orsp, rdy, unst, drop;
        logic [W-1:0] res, a0, b0, a1, b1;
        logic dz;
        logic [W:0] exp;
        a0 = $urandom; b0 = $urandom_range(1, 300);
        a1 = $urandom; b1 = $urandom_range(1, 300);
        set_req(0, 1'b1, a0, b0);
        wait_accept(port, waited, both, to);
        set_req(0, 1'b0, '0, '0);
        tb_last = 0;
        set_req(1, 1'b1, a1, b1);
        exp = ref_op(a0, b0);
        finish_op(0, 10, res, dz, lat, en, orsp, rdy, unst, drop, to);
        total++;
        if (to || port !== 0 || {dz, res} !== exp) begin
            bad++;
            $display("FAIL bp_result got=%0h want=%0h", {dz, res}, exp);
        end
        total++;
        if (unst || rdy || orsp || drop) begin
            bad++;
            $display("FAIL bp_hold unstable=%0b ready_seen=%0b other=%0b drop=%0b want 0 0 0 0", unst, rdy, orsp, drop);
        end
        exp = ref_op(a1, b1);
        wait_accept(port, waited, both, to);
        set_req(1, 1'b0, '0, '0);
        tb_last = 1;
        total++;
        if (to || port !== 1 || waited !== 0) begin
            bad++;
            $display("FAIL bp_next_accept got port=%0d waited=%0d want port=1 waited=0", port, waited);
        end
        finish_op(1, 0, res, dz, lat, en, orsp, rdy, unst, drop, to);
        total++;
        if (to || {dz, res} !== exp || lat !== 2 + L) begin
            bad++;
            $display("FAIL bp_second got=%0h lat=%0d want=%0h lat=%0d", {dz, res}, lat, exp, 2 + L);
        end
    endtask

    task automatic test_reset_busy();
        int port, waited, lat, en;
        bit both, to, orsp, rdy, unst, drop, leak;
        logic [W-1:0] res;
        logic dz;
        set_req(0, 1'b1, 1000, 3);
        wait_accept(port, waited, both, to);
        set_req(0, 1'b0, '0, '0);
        for (int i = 0; i < 21; i++) tick();
        total++;
        if (div_enable !== 1'b1) begin
            bad++;
            $display("FAIL rstbusy_enable got=%0b want=1", div_enable);
        end
        rstn = 1'b0;
        tick();
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL rstbusy_outputs got=%0h want=0", outs());
        end
        rstn = 1'b1;
        tb_last = 1;
        leak = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rsp0_valid || rsp1_valid || busy || div_enable) leak = 1;
        end
        total++;
        if (leak) begin
            bad++;
            $display("FAIL rstbusy_no_response got activity=1 want 0");
        end
        set_req(0, 1'b1, 50, 5);
        wait_accept(port, waited, both, to);
        set_req(0, 1'b0, '0, '0);
        tb_last = 0;
        finish_op(0, 0, res, dz, lat, en, orsp, rdy, unst, drop, to);
        total++;
        if (to || port !== 0 || res !== 10 || dz !== 1'b0 || lat !== 2 + L) begin
            bad++;
            $display("FAIL rstbusy_after got port=%0d q=%0d dz=%0b lat=%0d want 0 10 0 %0d", port, res, dz, lat, 2 + L);
        end
    endtask

    task automatic test_sweep();
        int port, waited, lat, en, idx;
        bit both, to, orsp, rdy, unst, drop;
        logic [W-1:0] res, a;
        logic dz;
        idx = 0;
        for (int k = 1; k <= 58; k += 3) begin
            int p;
            p = idx % 2;
            a = W'(k * k + 7);
            set_req(p, 1'b1, a, W'(k));
            wait_accept(port, waited, both, to);
            set_req(p, 1'b0, '0, '0);
            tb_last = p;
            finish_op(p, 0, res, dz, lat, en, orsp, rdy, unst, drop, to);
            total++;
            if (to || port !== p || res !== W'((k * k + 7) / k) || dz !== 1'b0 || lat !== 2 + L) begin
                bad++;
                $display("FAIL sweep k=%0d got port=%0d q=%0d dz=%0b lat=%0d want port=%0d q=%0d",
                         k, port, res, dz, lat, p, (k * k + 7) / k);
            end
            idx++;
        end
    endtask

    task automatic test_random();
        int port, waited, lat, en, p, bp, explat;
        bit both, to, orsp, rdy, unst, drop;
        logic [W-1:0] res, a, b;
        logic dz;
        logic [W:0] exp;
        for (int n = 0; n < 16; n++) begin
            p  = $urandom_range(0, 1);
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? '0 : (W'($urandom) >> $urandom_range(0, 31));
            bp = $urandom_range(0, 3);
            exp = ref_op(a, b);
            explat = (b == '0) ? 1 : 2 + L;
            set_req(p, 1'b1, a, b);
            wait_accept(port, waited, both, to);
            set_req(p, 1'b0, '0, '0);
            tb_last = p;
            finish_op(p, bp, res, dz, lat, en, orsp, rdy, unst, drop, to);
            total++;
            if (to || port !== p || {dz, res} !== exp || lat !== explat || unst || orsp || drop) begin
                bad++;
                $display("FAIL random n=%0d a=%0h b=%0h got=%0h lat=%0d want=%0h lat=%0d",
                         n, a, b, {dz, res}, lat, exp, explat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_div_zero();
        test_backpressure();
        test_reset_busy();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
